inst_rom_arbiter: RTL and testbench

Shares the single-ported, combinational instruction ROM between two requesters: the fetch stage (port IF) and the debug/loader read port (port DBG). Each cycle it grants at most one requester, drives the ROM chip-enable and address, and captures the read data into a per-port response register. The captured data is returned one cycle later with a valid pulse. Fetch has priority, and an anti-starvation counter bounds how long DBG can wait.

---
 rtl/inst_rom_arbiter_pkg.sv | 23 ++
 rtl/inst_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_arbiter_pkg
//  Description : Shared constants for the instruction ROM and its arbiter:
//                bus widths, zero word, chip-enable encodings and the
//                port identifiers used for last-grant visibility.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_rom_arbiter_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;

    localparam logic        PortIf      = 1'b0;
    localparam logic        PortDbg     = 1'b1;

endpackage : inst_rom_arbiter_pkg
`default_nettype wire

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_arbiter
//  Description : Shares the single-ported combinational instruction ROM
//                between the fetch port (IF) and the debug/loader port (DBG).
//                IF has priority; a saturating starve counter forces a DBG
//                grant after STARVE_MAX consecutive lost cycles. Read data is
//                captured per port and returned one cycle later with rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    import inst_rom_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              if_rvalid_q,  if_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;

    // Grant decision: IF wins ties unless DBG has waited STARVE_MAX cycles.
    // Reset low suppresses all grants so the ROM stays disabled.
    always_comb begin
        if_gnt  = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            if (if_req && dbg_req) begin
                if (starve_cnt_q == STARVE_LIM) begin
                    dbg_gnt = 1'b1;
                end else begin
                    if_gnt  = 1'b1;
                end
            end else if (if_req) begin
                if_gnt  = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    // ROM drive: enable and address follow whichever port holds the grant.
    always_comb begin
        rom_ce   = ChipDisable;
        rom_addr = ADDR_W'(ZeroWord);
        if (if_gnt) begin
            rom_ce   = ChipEnable;
            rom_addr = if_addr;
        end else if (dbg_gnt) begin
            rom_ce   = ChipEnable;
            rom_addr = dbg_addr;
        end
    end

    // Next-state for the starve counter and the per-port response registers.
    always_comb begin
        starve_cnt_d = '0;
        if (dbg_req && !dbg_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                        : starve_cnt_q + CNT_W'(1);
        end

        // A flush in the grant cycle kills the pulse but data still lands.
        if_rvalid_d  = if_gnt & ~if_flush;
        dbg_rvalid_d = dbg_gnt;
        if_rdata_d   = if_gnt  ? rom_data : if_rdata_q;
        dbg_rdata_d  = dbg_gnt ? rom_data : dbg_rdata_q;
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if_rdata_q   <= DATA_W'(ZeroWord);
            dbg_rdata_q  <= DATA_W'(ZeroWord);
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // A flush in the response cycle masks the IF pulse immediately.
    assign if_rvalid  = if_rvalid_q & ~if_flush;
    assign dbg_rvalid = dbg_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule : inst_rom_arbiter
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_rom_arbiter
//  Description : Directed self-checking bench for inst_rom_arbiter with a
//                combinational ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dbg_req;
    logic [31:0] if_addr, dbg_addr;
    logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, rom_ce;
    logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_data;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr[7:2]];

    inst_rom_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // Inputs change at negedge; checks happen 1ns later, mid-cycle.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic [31:0] da);
        @(negedge clk);
        if_req = ir; if_addr = ia; if_flush = fl; dbg_req = dr; dbg_addr = da;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 32'h4, 1'b0, ~i[0], 32'h8);
            checks++;
            if (if_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
                errors++; $display("FAIL reset_rvalid: if=%b dbg=%b required 0 0", if_rvalid, dbg_rvalid);
            end
            checks++;
            if (if_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
                errors++; $display("FAIL reset_rdata: if=%h dbg=%h required 0", if_rdata, dbg_rdata);
            end
            checks++;
            if (rom_ce !== 1'b0 || if_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
                errors++; $display("FAIL reset_ce: ce=%b ig=%b dg=%b required 0", rom_ce, if_gnt, dbg_gnt);
            end
        end
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (rom_ce !== 1'b0 || if_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
                errors++; $display("FAIL release_idle: ce=%b irv=%b drv=%b required 0", rom_ce, if_rvalid, dbg_rvalid);
            end
        end
    endtask

    task automatic test_if_only;
        logic [31:0] addrs [4];
        logic [31:0] words [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'h0};
        words = '{32'h0, 32'h34011100, 32'h34020020, 32'h3403ff00};
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, (i < 4) ? addrs[i] : 32'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (if_gnt !== (i < 3) || dbg_gnt !== 1'b0) begin
                errors++; $display("FAIL if_only_gnt[%0d]: ig=%b dg=%b required %b 0", i, if_gnt, dbg_gnt, i < 3);
            end
            if (i < 3) begin
                checks++;
                if (rom_ce !== 1'b1 || rom_addr !== addrs[i]) begin
                    errors++; $display("FAIL if_only_rom[%0d]: ce=%b addr=%h required 1 %h", i, rom_ce, rom_addr, addrs[i]);
                end
            end
            checks++;
            if (if_rvalid !== (i >= 1 && i <= 3)) begin
                errors++; $display("FAIL if_only_rvalid[%0d]: got %b required %b", i, if_rvalid, (i >= 1 && i <= 3));
            end
            if (i >= 1) begin
                checks++;
                if (if_rdata !== words[(i > 3) ? 3 : i]) begin
                    errors++; $display("FAIL if_only_rdata[%0d]: got %h required %h", i, if_rdata, words[(i > 3) ? 3 : i]);
                end
            end
        end
    endtask

    task automatic test_starvation;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'hC, 1'b0, i <= 5, 32'h10);
            checks++;
            if (if_gnt !== (i != 5) || dbg_gnt !== (i == 5)) begin
                errors++; $display("FAIL starve_gnt[c%0d]: ig=%b dg=%b required %b %b", i, if_gnt, dbg_gnt, i != 5, i == 5);
            end
            if (i == 5) begin
                checks++;
                if (rom_addr !== 32'h10) begin
                    errors++; $display("FAIL starve_addr: got %h required 00000010", rom_addr);
                end
            end
            if (i == 6) begin
                checks++;
                if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA5000004) begin
                    errors++; $display("FAIL starve_dbg_resp: rv=%b data=%h required 1 a5000004", dbg_rvalid, dbg_rdata);
                end
                checks++;
                if (if_rvalid !== 1'b0) begin
                    errors++; $display("FAIL starve_if_gap: rv=%b required 0", if_rvalid);
                end
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_dbg_only;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
        checks++;
        if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || rom_addr !== 32'h20) begin
            errors++; $display("FAIL dbg_only_gnt: dg=%b ig=%b addr=%h required 1 0 00000020", dbg_gnt, if_gnt, rom_addr);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h24);
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA5000008 || dbg_gnt !== 1'b1) begin
            errors++; $display("FAIL dbg_b2b_1: rv=%b data=%h g=%b required 1 a5000008 1", dbg_rvalid, dbg_rdata, dbg_gnt);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA5000009) begin
            errors++; $display("FAIL dbg_b2b_2: rv=%b data=%h required 1 a5000009", dbg_rvalid, dbg_rdata);
        end
        // Counter must start from zero: IF should win exactly four times.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h20);
            checks++;
            if (dbg_gnt !== (i == 5) || if_gnt !== (i != 5)) begin
                errors++; $display("FAIL dbg_cnt_zero[c%0d]: dg=%b ig=%b required %b %b", i, dbg_gnt, if_gnt, i == 5, i != 5);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_flush;
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL flush_gnt: got %b required 1", if_gnt);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h34020020) begin
            errors++; $display("FAIL flush_grant_cycle: rv=%b data=%h required 0 34020020", if_rvalid, if_rdata);
        end
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h3403ff00) begin
            errors++; $display("FAIL flush_rvalid_cycle: rv=%b data=%h required 0 3403ff00", if_rvalid, if_rdata);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h34011100) begin
            errors++; $display("FAIL flush_dbg_unaffected: rv=%b data=%h required 1 34011100", dbg_rvalid, dbg_rdata);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_read;
        drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h10);
        drive(1'b1, 32'h8, 1'b0, 1'b1, 32'h10);
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
        #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_rvalid: got %b required 0", if_rvalid);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (if_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
                errors++; $display("FAIL mid_reset_after[%0d]: irv=%b drv=%b required 0 0", i, if_rvalid, dbg_rvalid);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
            checks++;
            if (dbg_gnt !== (i == 5)) begin
                errors++; $display("FAIL mid_reset_cnt[c%0d]: dg=%b required %b", i, dbg_gnt, i == 5);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Grants must never overlap.
    always @(negedge clk) begin
        #2;
        if (if_gnt === 1'b1 && dbg_gnt === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL mutex: ig=%b dg=%b required not both 1", if_gnt, dbg_gnt);
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + i;
        mem[0] = 32'h34011100;
        mem[1] = 32'h34020020;
        mem[2] = 32'h3403ff00;
        rst = 1'b0; if_req = 1'b0; dbg_req = 1'b0; if_flush = 1'b0;
        if_addr = 32'h0; dbg_addr = 32'h0;

        test_reset();
        test_if_only();
        test_starvation();
        test_dbg_only();
        test_flush();
        test_reset_mid_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_inst_rom_arbiter
`default_nettype wire
